// File: rtl/usb_fifo_bridge_pkg.sv
// rtl/usb_fifo_bridge_pkg.sv - register map, control bits and sequencer states
package usb_fifo_bridge_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  localparam int CTRL_ENABLE          = 0;
  localparam int CTRL_RX_IRQ_EN       = 1;
  localparam int CTRL_TX_EMPTY_IRQ_EN = 2;
  localparam int CTRL_FLUSH           = 8;
  localparam int STATUS_TX_OVF        = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_STROBE,
    ST_WR_SETUP,
    ST_WR_STROBE,
    ST_WR_HOLD,
    ST_RECOVER
  } state_t;

endpackage

// File: rtl/usb_fifo_bridge_if.sv
// rtl/usb_fifo_bridge_if.sv - Avalon-MM register port of the USB FIFO bridge
interface usb_fifo_bridge_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (output address, chipselect, read_n, write_n, writedata,
                  input  readdata, irq);
  modport slave  (input  address, chipselect, read_n, write_n, writedata,
                  output readdata, irq);
endinterface

// File: rtl/usb_byte_fifo.sv
// rtl/usb_byte_fifo.sv - synchronous show-ahead byte FIFO with flush
module usb_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [7:0]             din,
  input  logic                   pop,
  input  logic                   flush,
  output logic [7:0]             dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Flush wins over any same-cycle push, so a byte arriving with it is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/usb_fifo_bridge.sv
// rtl/usb_fifo_bridge.sv - Avalon-MM to FT245-style USB FIFO strobe sequencer
module usb_fifo_bridge
  import usb_fifo_bridge_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int RD_PULSE   = 4,
  parameter int WR_PULSE   = 4,
  parameter int RECOVER    = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  usb_fifo_bridge_if.slave  bus,
  inout  wire  [7:0]        usb_d,
  input  logic              usb_rxf_n,
  input  logic              usb_txe_n,
  output logic              usb_rd_n,
  output logic              usb_wr
);
  localparam int CNTW    = $clog2(FIFO_DEPTH) + 1;
  localparam int P1      = (RD_PULSE > WR_PULSE) ? RD_PULSE : WR_PULSE;
  localparam int CNT_MAX = (P1 > RECOVER) ? P1 : RECOVER;
  localparam int CW      = $clog2(CNT_MAX + 1);
  // WR_SETUP already counts as the first high cycle of the write pulse.
  localparam int WR_STROBE_LEN = (WR_PULSE > 1) ? WR_PULSE - 1 : 1;

  logic [1:0]      rxf_sync, txe_sync;
  logic            rxf_s_n, txe_s_n;
  logic            av_wr, av_rd, flush, tx_push, tx_pop, rx_push, rx_pop;
  logic            tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0]      tx_dout, rx_dout, wr_byte;
  logic [CNTW-1:0] tx_count, rx_count;
  logic [2:0]      ctrl;
  logic            tx_ovf, rx_req, tx_req, busy_wr, last_wr, last_wr_n;
  logic [31:0]     readdata_q;
  logic [CW-1:0]   cnt, cnt_n;
  state_t          state, state_n;
  logic            unused_wdata;

  assign unused_wdata = ^bus.writedata[31:9];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxf_sync <= 2'b11;
      txe_sync <= 2'b11;
    end else begin
      rxf_sync <= {rxf_sync[0], usb_rxf_n};
      txe_sync <= {txe_sync[0], usb_txe_n};
    end
  end
  assign rxf_s_n = rxf_sync[1];
  assign txe_s_n = txe_sync[1];

  assign av_wr   = bus.chipselect & ~bus.write_n;
  assign av_rd   = bus.chipselect & ~bus.read_n;
  assign flush   = av_wr & (bus.address == ADDR_CTRL) & bus.writedata[CTRL_FLUSH];
  assign tx_push = av_wr & (bus.address == ADDR_DATA);
  assign rx_pop  = av_rd & (bus.address == ADDR_DATA);

  usb_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset_n(reset_n), .push(tx_push), .din(bus.writedata[7:0]),
    .pop(tx_pop), .flush(flush), .dout(tx_dout), .full(tx_full),
    .empty(tx_empty), .count(tx_count));

  usb_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset_n(reset_n), .push(rx_push), .din(usb_d),
    .pop(rx_pop), .flush(flush), .dout(rx_dout), .full(rx_full),
    .empty(rx_empty), .count(rx_count));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl       <= '0;
      tx_ovf     <= 1'b0;
      readdata_q <= '0;
    end else begin
      if (av_wr && bus.address == ADDR_CTRL) ctrl <= bus.writedata[2:0];
      if (tx_push && tx_full)
        tx_ovf <= 1'b1;
      else if (av_wr && bus.address == ADDR_STATUS && bus.writedata[STATUS_TX_OVF])
        tx_ovf <= 1'b0;
      case (bus.address)
        ADDR_DATA:   readdata_q <= rx_empty ? 32'd0 : {23'd0, 1'b1, rx_dout};
        ADDR_STATUS: readdata_q <= {8'd0, 8'(tx_count), 8'(rx_count), 5'd0,
                                    tx_ovf, tx_full, ~rx_empty};
        ADDR_CTRL:   readdata_q <= {29'd0, ctrl};
        default:     readdata_q <= 32'd0;
      endcase
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.irq = (ctrl[CTRL_RX_IRQ_EN] & ~rx_empty) |
                   (ctrl[CTRL_TX_EMPTY_IRQ_EN] & tx_empty & ~busy_wr);

  assign rx_req = ctrl[CTRL_ENABLE] & ~rxf_s_n & ~rx_full & ~flush;
  assign tx_req = ctrl[CTRL_ENABLE] & ~txe_s_n & ~tx_empty & ~flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      last_wr <= 1'b1;
      wr_byte <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      last_wr <= last_wr_n;
      if (state == ST_WR_SETUP) wr_byte <= tx_dout;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    last_wr_n = last_wr;
    rx_push   = 1'b0;
    tx_pop    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_req && (!tx_req || last_wr)) begin
          state_n   = ST_RD_STROBE;
          cnt_n     = CW'(RD_PULSE - 1);
          last_wr_n = 1'b0;
        end else if (tx_req) begin
          state_n   = ST_WR_SETUP;
          last_wr_n = 1'b1;
        end
      end
      ST_RD_STROBE: begin
        if (cnt == '0) begin
          rx_push = 1'b1;
          state_n = ST_RECOVER;
          cnt_n   = CW'(RECOVER - 1);
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      ST_WR_SETUP: begin
        tx_pop = 1'b1;
        if (WR_PULSE > 1) begin
          state_n = ST_WR_STROBE;
          cnt_n   = CW'(WR_STROBE_LEN - 1);
        end else begin
          state_n = ST_WR_HOLD;
        end
      end
      ST_WR_STROBE: begin
        if (cnt == '0) state_n = ST_WR_HOLD;
        else           cnt_n   = cnt - CW'(1);
      end
      ST_WR_HOLD: begin
        state_n = ST_RECOVER;
        cnt_n   = CW'(RECOVER - 1);
      end
      ST_RECOVER: begin
        if (cnt == '0) state_n = ST_IDLE;
        else           cnt_n   = cnt - CW'(1);
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Strobes decode straight from the state register so reset releases them at once.
  assign busy_wr  = (state == ST_WR_SETUP) || (state == ST_WR_STROBE) || (state == ST_WR_HOLD);
  assign usb_rd_n = (state != ST_RD_STROBE);
  assign usb_wr   = (state == ST_WR_SETUP) || (state == ST_WR_STROBE);
  assign usb_d    = busy_wr ? ((state == ST_WR_SETUP) ? tx_dout : wr_byte) : 8'hzz;
endmodule

// File: tb/tb_usb_fifo_bridge.sv
// tb/tb_usb_fifo_bridge.sv - randomized self-checking bench with chip and FIFO reference model
module tb_usb_fifo_bridge;
  import usb_fifo_bridge_pkg::*;

  localparam int DEPTH    = 16;
  localparam int RD_PULSE = 4;
  localparam int WR_PULSE = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  usb_fifo_bridge_if bus();
  wire  [7:0] usb_d;
  logic       usb_rxf_n, usb_txe_n, usb_rd_n, usb_wr;

  usb_fifo_bridge #(.FIFO_DEPTH(DEPTH), .RD_PULSE(RD_PULSE), .WR_PULSE(WR_PULSE), .RECOVER(2)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave), .usb_d(usb_d),
    .usb_rxf_n(usb_rxf_n), .usb_txe_n(usb_txe_n), .usb_rd_n(usb_rd_n), .usb_wr(usb_wr));

  // An undriven bus reads as 0xFF, so a released bus is visible.
  pullup (usb_d);

  logic [7:0] chip_buf [256];
  int         chip_wr = 0, chip_rd = 0;
  logic       rxf_hold = 1'b1, txe_hold = 1'b1;
  logic [7:0] chip_d;
  assign chip_d    = chip_buf[chip_rd[7:0]];
  assign usb_d     = usb_rd_n ? 8'hzz : chip_d;
  assign usb_rxf_n = rxf_hold | (chip_wr == chip_rd);
  assign usb_txe_n = txe_hold;

  logic [7:0] tx_model[$];
  logic [7:0] rx_model[$];
  bit         dir_log[$];
  logic [7:0] cur_wr = 8'h00;
  bit         armed = 1'b0, mon_on = 1'b0;
  int         n_written = 0;
  int         n_checks = 0, n_pass = 0;
  int         wr_hi = 0, rd_lo = 0;
  bit         post_hold = 1'b0;
  logic [31:0] rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic av_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = a; bus.writedata = d;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic av_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.chipselect = 1'b1; bus.read_n = 1'b0; bus.address = a;
    @(posedge clk); #1 d = bus.readdata;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.read_n = 1'b1;
  endtask

  // Expected DATA value is taken from the model at the cycle the read is issued.
  task automatic read_data_chk(input string tag);
    logic [31:0] exp;
    logic [31:0] got;
    @(negedge clk);
    bus.chipselect = 1'b1; bus.read_n = 1'b0; bus.address = ADDR_DATA;
    if (rx_model.size() != 0) exp = {23'd0, 1'b1, rx_model.pop_front()};
    else                      exp = 32'd0;
    @(posedge clk); #1 got = bus.readdata;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.read_n = 1'b1;
    check(tag, got, exp);
  endtask

  initial forever begin
    @(posedge usb_rd_n);
    if (armed) begin
      check("rx_room", 32'(rx_model.size() < DEPTH), 32'd1);
      rx_model.push_back(chip_buf[chip_rd[7:0]]);
      chip_rd++;
      dir_log.push_back(1'b0);
    end
  end

  initial forever begin
    @(posedge usb_wr);
    if (armed) begin
      check("wr_has_data", 32'(tx_model.size() != 0), 32'd1);
      cur_wr = (tx_model.size() != 0) ? tx_model[0] : 8'h00;
      dir_log.push_back(1'b1);
    end
  end

  initial forever begin
    @(negedge usb_wr);
    if (armed) begin
      check("wr_latch", usb_d, cur_wr);
      if (tx_model.size() != 0) void'(tx_model.pop_front());
      n_written++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!mon_on) begin
      wr_hi = 0; rd_lo = 0; post_hold = 1'b0;
    end else begin
      if (usb_wr) begin
        wr_hi++;
        check("wr_drive", usb_d, cur_wr);
        check("rd_during_wr", usb_rd_n, 1'b1);
      end else if (wr_hi != 0) begin
        check("wr_width", wr_hi, WR_PULSE);
        check("wr_hold_data", usb_d, cur_wr);
        wr_hi = 0; post_hold = 1'b1;
      end else if (post_hold) begin
        check("wr_release", usb_d, 8'hFF);
        post_hold = 1'b0;
      end
      if (!usb_rd_n) begin
        rd_lo++;
        check("rd_bus", usb_d, chip_buf[chip_rd[7:0]]);
      end else if (rd_lo != 0) begin
        check("rd_width", rd_lo, RD_PULSE);
        rd_lo = 0;
      end
    end
  end

  initial begin
    bus.chipselect = 1'b0; bus.read_n = 1'b1; bus.write_n = 1'b1;
    bus.address = 2'd0; bus.writedata = 32'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    armed = 1'b1; mon_on = 1'b1;

    check("reset_readdata", bus.readdata, 32'd0);
    check("reset_irq", bus.irq, 1'b0);
    check("reset_rd_n", usb_rd_n, 1'b1);
    check("reset_wr", usb_wr, 1'b0);
    check("reset_bus_z", usb_d, 8'hFF);
    av_read(ADDR_STATUS, rd);
    check("reset_status", rd, 32'd0);

    // Single read from the chip.
    av_write(ADDR_CTRL, 32'h1);
    rxf_hold = 1'b0;
    chip_buf[chip_wr[7:0]] = 8'hA5; chip_wr++;
    for (int i = 0; i < 100 && rx_model.size() == 0; i++) @(posedge clk);
    check("rx_arrived", 32'(rx_model.size()), 32'd1);
    av_read(ADDR_DATA, rd);
    check("rx_a5", rd, 32'h1A5);
    if (rx_model.size() != 0) void'(rx_model.pop_front());
    av_read(ADDR_DATA, rd);
    check("rx_empty_read", rd, 32'd0);

    // Single write to the chip.
    txe_hold = 1'b0;
    repeat (3) @(posedge clk);
    tx_model.push_back(8'h3C);
    av_write(ADDR_DATA, 32'h3C);
    av_read(ADDR_STATUS, rd);
    check("tx_count_1", rd, 32'h0001_0000);
    for (int i = 0; i < 100 && n_written < 1; i++) @(posedge clk);
    check("tx_written", n_written, 1);
    av_read(ADDR_STATUS, rd);
    check("tx_count_0", rd, 32'd0);

    // Overflow, sticky flag clear, flush.
    txe_hold = 1'b1; rxf_hold = 1'b1;
    repeat (4) @(posedge clk);
    for (int i = 0; i < DEPTH + 1; i++) begin
      if (i < DEPTH) tx_model.push_back(8'(i));
      av_write(ADDR_DATA, 32'(i));
    end
    av_read(ADDR_STATUS, rd);
    check("tx_full_ovf", rd, 32'h0010_0006);
    av_write(ADDR_STATUS, 32'h4);
    av_read(ADDR_STATUS, rd);
    check("ovf_cleared", rd, 32'h0010_0002);
    check("no_wr_blocked", n_written, 1);
    av_write(ADDR_CTRL, 32'h101);
    tx_model.delete();
    av_read(ADDR_STATUS, rd);
    check("flushed", rd, 32'd0);
    av_write(ADDR_CTRL, 32'h5);
    @(negedge clk);
    check("irq_tx_empty", bus.irq, 1'b1);
    av_write(ADDR_CTRL, 32'h1);
    @(negedge clk);
    check("irq_off", bus.irq, 1'b0);

    // Both directions pending: round-robin starting with a read.
    for (int i = 0; i < 2; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 254));
      tx_model.push_back(b);
      av_write(ADDR_DATA, {24'd0, b});
      chip_buf[chip_wr[7:0]] = 8'($urandom_range(0, 255)); chip_wr++;
    end
    repeat (4) @(posedge clk);
    dir_log.delete();
    @(negedge clk);
    rxf_hold = 1'b0; txe_hold = 1'b0;
    for (int i = 0; i < 300 && dir_log.size() < 4; i++) @(posedge clk);
    check("rr_count", 32'(dir_log.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check("rr_order", (i < dir_log.size()) ? 32'(dir_log[i]) : 32'hDEAD, 32'(i % 2));
    read_data_chk("rr_rx0");
    read_data_chk("rr_rx1");

    // Randomized traffic against the reference model.
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 5))
        0: if (tx_model.size() < 12) begin
             logic [7:0] b;
             b = 8'($urandom_range(0, 254));
             tx_model.push_back(b);
             av_write(ADDR_DATA, {24'd0, b});
           end
        1: read_data_chk("rand_rx");
        2: if (chip_wr - chip_rd < 6) begin
             chip_buf[chip_wr[7:0]] = 8'($urandom_range(0, 255));
             chip_wr++;
           end
        3: rxf_hold = 1'($urandom_range(0, 1));
        4: txe_hold = 1'($urandom_range(0, 1));
        default: repeat ($urandom_range(1, 8)) @(posedge clk);
      endcase
    end
    rxf_hold = 1'b0; txe_hold = 1'b0;
    for (int i = 0; i < 400 && (chip_rd != chip_wr || tx_model.size() != 0); i++)
      read_data_chk("drain_rx");
    check("drain_done", 32'(chip_rd == chip_wr && tx_model.size() == 0), 32'd1);
    repeat (20) @(posedge clk);
    av_read(ADDR_STATUS, rd);
    check("final_status", rd, (32'(rx_model.size()) << 8) | 32'(rx_model.size() != 0));
    while (rx_model.size() != 0) read_data_chk("final_rx");

    // Reset in the middle of the write strobe.
    txe_hold = 1'b1;
    repeat (4) @(posedge clk);
    tx_model.push_back(8'h77);
    av_write(ADDR_DATA, 32'h77);
    txe_hold = 1'b0;
    for (int i = 0; i < 50 && !usb_wr; i++) @(posedge clk);
    @(posedge clk); @(posedge clk); #2;
    check("wr_mid", usb_wr, 1'b1);
    armed = 1'b0; mon_on = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rst_wr_async", usb_wr, 1'b0);
    check("rst_bus_async", usb_d, 8'hFF);
    check("rst_rd_async", usb_rd_n, 1'b1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    tx_model.delete(); rx_model.delete();
    repeat (6) @(posedge clk);
    av_read(ADDR_STATUS, rd);
    check("post_rst_status", rd, 32'd0);
    av_read(ADDR_CTRL, rd);
    check("post_rst_ctrl", rd, 32'd0);
    check("post_rst_idle_wr", usb_wr, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
